// File: rtl/scr1_dmem_arb.sv
// Two-port round-robin arbiter in front of the data memory port (port 0 = LSU, port 1 = system bus).
// One transaction outstanding at a time; a response watchdog aborts hung transactions with an error.
module scr1_dmem_arb #(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_cmd,
    input  logic [1:0]        m0_width,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_req_ack,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic [1:0]        m0_resp,

    input  logic              m1_req,
    input  logic              m1_cmd,
    input  logic [1:0]        m1_width,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_req_ack,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [1:0]        m1_resp,

    output logic              dmem_req,
    output logic              dmem_cmd,
    output logic [1:0]        dmem_width,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_req_ack,
    input  logic [DWIDTH-1:0] dmem_rdata,
    input  logic [1:0]        dmem_resp,

    output logic              arb_timeout
);

    localparam logic [1:0]  RespNotRdy = 2'b00;
    localparam logic [1:0]  RespRdyOk  = 2'b01;
    localparam logic [1:0]  RespRdyEr  = 2'b10;
    localparam logic [15:0] WdogLast   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_t;

    state_t      state_q;
    logic        owner_q;
    logic        rr_last_q;
    logic        lock_q;
    logic        lock_id_q;
    logic [15:0] wdog_q;

    logic        st_idle;
    logic        st_busy;
    logic        sel;
    logic        sel_req;
    logic        resp_valid;
    logic        wdog_fire;
    logic [1:0]  owner_resp;
    logic [DWIDTH-1:0] owner_rdata;

    assign st_idle = (state_q == StIdle);
    assign st_busy = (state_q == StBusy);

    // A pending unacked selection is pinned so the handshake never switches ports.
    always_comb begin
        if (lock_q) begin
            sel = lock_id_q;
        end else if (m0_req ^ m1_req) begin
            sel = m1_req;
        end else begin
            sel = ~rr_last_q;
        end
    end

    assign sel_req  = sel ? m1_req : m0_req;
    assign dmem_req = st_idle & sel_req;

    always_comb begin
        dmem_cmd   = 1'b0;
        dmem_width = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (dmem_req) begin
            dmem_cmd   = sel ? m1_cmd   : m0_cmd;
            dmem_width = sel ? m1_width : m0_width;
            dmem_addr  = sel ? m1_addr  : m0_addr;
            dmem_wdata = sel ? m1_wdata : m0_wdata;
        end
    end

    assign m0_req_ack = dmem_req & dmem_req_ack & ~sel;
    assign m1_req_ack = dmem_req & dmem_req_ack &  sel;

    assign resp_valid = (dmem_resp != RespNotRdy);
    assign wdog_fire  = st_busy & ~resp_valid & (wdog_q == WdogLast);
    assign arb_timeout = wdog_fire;

    // Encoding 11 is folded into RDY_ER; a watchdog expiry also reports RDY_ER.
    always_comb begin
        owner_resp  = RespNotRdy;
        owner_rdata = '0;
        if (st_busy) begin
            if (resp_valid) begin
                owner_resp  = (dmem_resp == RespRdyOk) ? RespRdyOk : RespRdyEr;
                owner_rdata = dmem_rdata;
            end else if (wdog_fire) begin
                owner_resp  = RespRdyEr;
            end
        end
    end

    assign m0_resp  = owner_q ? RespNotRdy : owner_resp;
    assign m1_resp  = owner_q ? owner_resp : RespNotRdy;
    assign m0_rdata = owner_q ? '0 : owner_rdata;
    assign m1_rdata = owner_q ? owner_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lock_q && !sel_req) begin
                        lock_q <= 1'b0;
                    end else if (dmem_req && dmem_req_ack) begin
                        owner_q   <= sel;
                        rr_last_q <= sel;
                        lock_q    <= 1'b0;
                        wdog_q    <= '0;
                        state_q   <= StBusy;
                    end else if (dmem_req) begin
                        lock_q    <= 1'b1;
                        lock_id_q <= sel;
                    end
                end
                StBusy: begin
                    if (resp_valid) begin
                        state_q <= StIdle;
                    end else if (wdog_q == WdogLast) begin
                        state_q <= StAbort;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                StAbort: begin
                    // Swallow the late response of the aborted transaction.
                    if (resp_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Self-checking bench for scr1_dmem_arb: vector table of single transactions plus
// hand-written round-robin, lock, watchdog and reset sequences, checked through a response scoreboard.
module tb_scr1_dmem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_cmd, m1_req, m1_cmd;
    logic [1:0]  m0_width, m1_width;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_req_ack, m1_req_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_resp, m1_resp;
    logic        dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        arb_timeout;

    always #5 clk = ~clk;

    scr1_dmem_arb #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .arb_timeout(arb_timeout)
    );

    typedef struct {
        logic        port;
        logic        cmd;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic        port;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic idle_in();
        m0_req = 0; m0_cmd = 0; m0_width = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_cmd = 0; m1_width = 0; m1_addr = 0; m1_wdata = 0;
        dmem_req_ack = 0; dmem_rdata = 0; dmem_resp = 0;
    endtask

    task automatic set_req(input logic p, input logic c, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            m1_req = 1; m1_cmd = c; m1_width = w; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = 1; m0_cmd = c; m0_width = w; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); idle_in(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    // Pop the scoreboard when a port shows a response and compare owner, code and data.
    task automatic collect(input string nm);
        exp_t e;
        logic p;
        chk({nm, "_seen"}, 64'((m0_resp != 0) || (m1_resp != 0)), 64'd1);
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: got empty scoreboard expected an entry", nm);
            return;
        end
        n_pass++;
        e = sb.pop_front();
        p = (m1_resp != 0);
        chk({nm, "_port"}, 64'(p), 64'(e.port));
        chk({nm, "_resp"}, 64'(p ? m1_resp : m0_resp), 64'(e.resp));
        chk({nm, "_rdata"}, 64'(p ? m1_rdata : m0_rdata), 64'(e.rdata));
        chk({nm, "_other_resp"}, 64'(p ? m0_resp : m1_resp), 64'd0);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        @(negedge clk); idle_in();
        set_req(v.port, v.cmd, v.width, v.addr, v.wdata);
        dmem_req_ack = 1;
        #1;
        chk({nm, "_ack"}, 64'(v.port ? m1_req_ack : m0_req_ack), 64'd1);
        chk({nm, "_ack_other"}, 64'(v.port ? m0_req_ack : m1_req_ack), 64'd0);
        chk({nm, "_dreq"}, 64'(dmem_req), 64'd1);
        chk({nm, "_daddr"}, 64'(dmem_addr), 64'(v.addr));
        chk({nm, "_dfields"}, {31'd0, dmem_cmd, dmem_width, dmem_wdata},
            {31'd0, v.cmd, v.width, v.wdata});
        sb.push_back('{port: v.port, resp: v.exp_resp, rdata: v.rdata});
        for (int i = 1; i < v.lat; i++) begin
            @(negedge clk); idle_in();
            dmem_rdata = $urandom;
            #1;
            chk({nm, "_wait_resp"}, {m0_resp, m1_resp, m0_rdata, m1_rdata}, 64'd0);
            chk({nm, "_wait_tmo"}, 64'(arb_timeout), 64'd0);
        end
        @(negedge clk); idle_in();
        dmem_resp = v.resp; dmem_rdata = v.rdata;
        #1;
        collect(nm);
        chk({nm, "_no_tmo"}, 64'(arb_timeout), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        logic g;
        vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 2, 2'b01, 32'hDEAD_BEEF, 2'b01};
        vecs[1] = '{1'b1, 1'b1, 2'b00, 32'h0000_2003, 32'hA5, 1, 2'b10, 32'h0, 2'b10};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h0000_0042, 32'h0, 3, 2'b11, 32'h1234, 2'b10};
        // Response lands exactly when the watchdog would expire: forwarded, no abort.
        vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h8000_0000, 32'h0, 4, 2'b01, 32'hCAFE_F00D, 2'b01};

        idle_in(); rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        // Reset state: idle inputs plus a stray memory response must all read as zero.
        @(negedge clk); idle_in();
        dmem_req_ack = 1; dmem_resp = 2'b01; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_dmem", {dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata[27:0]}, 64'd0);
        chk("rst_acks", {m0_req_ack, m1_req_ack, arb_timeout}, 64'd0);
        chk("rst_resp", {m0_resp, m1_resp, m0_rdata, m1_rdata}, 64'd0);

        for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Tie after an m1 grant: m0 must win.
        @(negedge clk); idle_in();
        set_req(0, 0, 2'b10, 32'h10, 0); set_req(1, 0, 2'b10, 32'h20, 0);
        dmem_req_ack = 1;
        #1;
        chk("tie_m0_ack", {m0_req_ack, m1_req_ack}, 64'b10);
        sb.push_back('{port: 1'b0, resp: 2'b01, rdata: 32'h5});
        @(negedge clk); idle_in(); dmem_resp = 2'b01; dmem_rdata = 32'h5;
        #1;
        collect("tie");

        // Round-robin with both requesters held high.
        do_reset();
        g = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); idle_in();
            set_req(0, 0, 2'b10, 32'h1000, 0); set_req(1, 1, 2'b10, 32'h2000, 32'h77);
            dmem_req_ack = 1;
            #1;
            chk($sformatf("rr%0d_acks", t), {m0_req_ack, m1_req_ack}, g ? 64'b01 : 64'b10);
            chk($sformatf("rr%0d_addr", t), 64'(dmem_addr), g ? 64'h2000 : 64'h1000);
            sb.push_back('{port: g, resp: 2'b01, rdata: 32'hA0 + t});
            @(negedge clk);
            dmem_resp = 2'b01; dmem_rdata = 32'hA0 + t;
            #1;
            collect($sformatf("rr%0d", t));
            chk($sformatf("rr%0d_busy_acks", t), {dmem_req, m0_req_ack, m1_req_ack}, 64'd0);
            g = ~g;
        end

        // Lock: m1 selection pinned while m0 joins and ack is withheld.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle_in();
            set_req(1, 1, 2'b10, 32'h3000, 32'h33);
            if (c >= 1) set_req(0, 0, 2'b10, 32'h4000, 0);
            dmem_req_ack = (c == 3);
            #1;
            chk($sformatf("lock%0d_addr", c), 64'(dmem_addr), 64'h3000);
            chk($sformatf("lock%0d_acks", c), {m0_req_ack, m1_req_ack}, (c == 3) ? 64'b01 : 64'b00);
        end
        sb.push_back('{port: 1'b1, resp: 2'b01, rdata: 32'h11});
        @(negedge clk); idle_in();
        set_req(0, 0, 2'b10, 32'h4000, 0); dmem_req_ack = 1;
        dmem_resp = 2'b01; dmem_rdata = 32'h11;
        #1;
        collect("lock_m1");
        chk("lock_busy_m0_ack", 64'(m0_req_ack), 64'd0);
        @(negedge clk); dmem_resp = 0; dmem_rdata = 0;
        #1;
        chk("lock_m0_grant", {m0_req_ack, m1_req_ack}, 64'b10);
        chk("lock_m0_addr", 64'(dmem_addr), 64'h4000);
        sb.push_back('{port: 1'b0, resp: 2'b01, rdata: 32'h22});
        @(negedge clk); idle_in(); dmem_resp = 2'b01; dmem_rdata = 32'h22;
        #1;
        collect("lock_m0");

        // Watchdog: m0 store never answered.
        @(negedge clk); idle_in();
        set_req(0, 1, 2'b10, 32'h300, 32'h55); dmem_req_ack = 1;
        #1;
        chk("wd_accept", 64'(m0_req_ack), 64'd1);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk); idle_in();
            #1;
            chk($sformatf("wd%0d_quiet", c), {arb_timeout, m0_resp, m1_resp}, 64'd0);
        end
        @(negedge clk); idle_in();
        #1;
        chk("wd_fire_resp", {m0_resp, m1_resp}, 64'b1000);
        chk("wd_fire_pulse", 64'(arb_timeout), 64'd1);
        for (int c = 5; c < 8; c++) begin
            @(negedge clk); idle_in();
            set_req(1, 0, 2'b10, 32'h600, 0); dmem_req_ack = 1;
            if (c == 7) begin dmem_resp = 2'b01; dmem_rdata = 32'hBAD; end
            #1;
            chk($sformatf("wd%0d_abort", c),
                {arb_timeout, dmem_req, m1_req_ack, m0_resp, m1_resp, m0_rdata, m1_rdata}, 64'd0);
        end
        @(negedge clk); dmem_resp = 0; dmem_rdata = 0;
        #1;
        chk("wd_m1_grant", {dmem_req, m1_req_ack}, 64'b11);
        chk("wd_m1_addr", 64'(dmem_addr), 64'h600);
        sb.push_back('{port: 1'b1, resp: 2'b01, rdata: 32'h42});
        @(negedge clk); idle_in(); dmem_resp = 2'b01; dmem_rdata = 32'h42;
        #1;
        collect("wd_m1");

        // Reset while an m0 read is outstanding, then a stray response.
        @(negedge clk); idle_in();
        set_req(0, 0, 2'b10, 32'h500, 0); dmem_req_ack = 1;
        #1;
        chk("rb_accept", 64'(m0_req_ack), 64'd1);
        @(negedge clk); idle_in(); rst = 1;
        @(negedge clk); rst = 0; dmem_resp = 2'b01; dmem_rdata = 32'h77;
        #1;
        chk("rb_stray", {dmem_req, m0_resp, m1_resp, m0_rdata, m1_rdata}, 64'd0);
        @(negedge clk); idle_in();
        set_req(1, 1, 2'b00, 32'h600, 32'h9); dmem_req_ack = 1;
        #1;
        chk("rb_new_ack", {dmem_req, m1_req_ack}, 64'b11);
        sb.push_back('{port: 1'b1, resp: 2'b01, rdata: 32'h99});
        @(negedge clk); idle_in(); dmem_resp = 2'b01; dmem_rdata = 32'h99;
        #1;
        collect("rb_m1");

        @(negedge clk); idle_in();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_arb.md
Name: scr1_dmem_arb

Overview:
- Two-requester arbiter for the single data memory port.
- Port 0 is the LSU (pipeline); port 1 is the system/debug bus master.
- Round-robin grant, at most one outstanding transaction, response routed back to the owner.
- Per-transaction response watchdog returns an error when the target hangs.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- TIMEOUT, 255, cycles in BUSY without a response before abort; legal range 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m0_req / m1_req  in  1  request, held until req_ack.
- m0_cmd / m1_cmd  in  1  0=RD, 1=WR.
- m0_width / m1_width  in  2  00 byte, 01 hword, 10 word.
- m0_addr / m1_addr  in  AWIDTH  address.
- m0_wdata / m1_wdata  in  DWIDTH  store data.
- m0_req_ack / m1_req_ack  out  1  request accepted.
- m0_rdata / m1_rdata  out  DWIDTH  load data.
- m0_resp / m1_resp  out  2  00 NOTRDY, 01 RDY_OK, 10 RDY_ER.
- dmem_req  out  1  request to memory.
- dmem_cmd  out  1  forwarded command.
- dmem_width  out  2  forwarded width.
- dmem_addr  out  AWIDTH  forwarded address.
- dmem_wdata  out  DWIDTH  forwarded store data.
- dmem_req_ack  in  1  memory accepted request.
- dmem_rdata  in  DWIDTH  memory load data.
- dmem_resp  in  2  memory response.
- arb_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- FSM states: IDLE, BUSY, ABORT. Registers:
  - owner (1b)
  - rr_last (1b): last granted port
  - lock (1b) and lock_id (1b): pending unacked selection
  - wdog counter (16b)
- Reset (rst high at a clock edge):
  - FSM=IDLE, owner=0, rr_last=1 (so port 0 wins the first tie), lock=0, wdog=0.
  - All outputs combinationally 0 while in IDLE with no requests, except rdata, which is 0 whenever resp is NOTRDY.
- Selection in IDLE:
  - If lock is set, sel=lock_id.
  - Otherwise: if only one req is high, sel is that port; if both are high, sel=~rr_last.
- Forwarding in IDLE:
  - dmem_req = req of sel.
  - cmd/width/addr/wdata are muxed from sel, zero-latency.
  - req_ack is given only to sel: mX_req_ack = dmem_req_ack & (sel==X) & IDLE.
  - The non-selected port sees req_ack=0.
- Lock:
  - If sel requests and dmem_req_ack=0, set lock=1 and lock_id=sel.
  - The selection stays fixed until acked, even if the other port raises req (no grant switching mid-handshake).
  - If the locked requester drops req, clear lock.
- Accept (IDLE, dmem_req & dmem_req_ack): owner<=sel, rr_last<=sel, lock<=0, wdog<=0, FSM<=BUSY.
- BUSY:
  - dmem_req=0; no req_ack to anyone.
  - dmem_resp and dmem_rdata route to owner in the same cycle; the other port sees NOTRDY and rdata 0.
  - On RDY_OK or RDY_ER: FSM<=IDLE. A new grant is possible the next cycle (1 dead cycle between transactions).
  - Otherwise wdog++. When wdog==TIMEOUT-1 with no response:
    - owner gets RDY_ER that cycle and arb_timeout=1.
    - FSM<=ABORT.
- ABORT:
  - dmem_req=0; both ports see NOTRDY.
  - The next RDY_OK/RDY_ER from memory is swallowed (not forwarded), then FSM<=IDLE.
  - No new grants until then.
- A response arriving in the same cycle the watchdog expires is forwarded normally, with no abort and no arb_timeout.
- A dmem_resp other than NOTRDY while in IDLE is ignored (dropped).
- Reset mid-transaction: the FSM returns to IDLE immediately. A later stray response is ignored per the IDLE rule.
- resp encoding 11 is treated as RDY_ER.

Test Plan:
- Single LSU load:
  - Stimulus: m0_req=1, RD word, addr 0x100, ack same cycle, resp OK with rdata 0xDEADBEEF 2 cycles later.
  - Required: m0_req_ack=1 in cycle 0; m0_resp=01 with m0_rdata=0xDEADBEEF; m1_resp=00 throughout.
- Round-robin:
  - Stimulus: m0_req and m1_req both held high for 4 transactions, each with 1-cycle latency.
  - Required: grant order 0,1,0,1; dmem_addr follows the granted port.
- Lock:
  - Stimulus: m1_req alone with dmem_req_ack=0 for 3 cycles; m0_req rises in cycle 1; ack in cycle 3.
  - Required: dmem_addr stays m1_addr cycles 0-3; m1 is granted, not m0; m0 is granted after m1's response.
- Watchdog:
  - Stimulus: TIMEOUT=4, m0 store accepted, no response.
  - Required: 4 cycles after accept, m0_resp=10 and arb_timeout=1. A late resp=01 at cycle 7 is not seen by either port. m1_req is granted the cycle after the late response.
- Error routing:
  - Stimulus: m1 write answered with RDY_ER.
  - Required: m1_resp=10, m0_resp=00, rr_last=1.
- Reset mid-BUSY:
  - Stimulus: rst asserted during an outstanding m0 read, then a stray resp=01.
  - Required: dmem_req=0, both resp=00, and a new request is accepted immediately after reset.
